spi_flash_target: RTL and testbench
===================================

Name: spi_flash_target

Overview:
- Bus responder for the flash request interface issued by the MIDI controller: request fields adr/dat/we/stb/tga, answered with dat/ack/rty.
- Converts each request into SPI NOR flash transactions, SPI mode 0, MSB first:
  - read: 0x03
  - page program: 0x06 then 0x02
  - sector erase: 0x06 then 0x20
  - optional status poll: 0x05
- Sits between the controller's storage logic and the board flash pins.

Parameters:
- CLK_DIV, 2: clk cycles per SPI clock half-period (≥1); one SPI bit = 2*CLK_DIV clk cycles.
- CS_GAP, 4: minimum clk cycles spi_cs stays high between two flash commands.
- POLL_MAX, 65535: maximum status-register reads before giving up (used only with the optional feature).

Ports:
- clk    in   1   system clock
- rst    in   1   reset, asynchronous, active-high
- adr_i  in   24  flash byte address
- dat_i  in   32  write word; dat_i[31:24] goes to adr_i, then descending bytes
- we_i   in   1   1=program/erase, 0=read
- stb_i  in   1   request strobe, held high until ack_o or rty_o
- tga_i  in   1   with we_i=1: 1=sector erase, 0=page program
- dat_o  out  32  read word; first byte read lands in [31:24]
- ack_o  out  1   one-cycle completion pulse
- rty_o  out  1   one-cycle failure pulse; requester should retry later
- spi_clk out 1   SPI clock, idles low
- spi_cs  out 1   chip select, active low
- spi_di  out 1   data into flash (MOSI)
- spi_do  in  1   data from flash (MISO)

Behaviour:
- Clock/reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: spi_cs=1, spi_clk=0, spi_di=0, dat_o=0, ack_o=0, rty_o=0, state IDLE, gap counter loaded with CS_GAP. Reset mid-transaction aborts immediately; no ack is produced.
- FSM states: IDLE, WREN, GAP, XFER, POLL, DONE.
- IDLE:
  - Accepts a request when stb_i=1 and the gap counter has expired.
  - Latches adr_i, dat_i, we_i, tga_i.
  - Illegal combination tga_i=1, we_i=0: rty_o pulses the next cycle, no SPI activity, go to DONE.
- Request routing after acceptance:
  - we=1: WREN.
  - we=0: XFER with read frame.
- WREN:
  - spi_cs low the cycle after acceptance; shift 8 bits of 0x06; raise spi_cs.
  - Go to GAP, then XFER.
- GAP: hold spi_cs high for CS_GAP cycles.
- XFER frames (one contiguous cs-low frame each):
  - read: 0x03 + 24-bit address + 32 read bits = 64 SPI clocks.
  - program: 0x02 + address + 32 data bits = 64 clocks.
  - erase: 0x20 + address = 32 clocks.
- SPI bit timing:
  - spi_di changes only while spi_clk is low, CLK_DIV cycles before each rising edge.
  - spi_do is sampled on the clk cycle in which spi_clk rises.
  - spi_clk is low when spi_cs rises.
- Read completion: dat_o updated at end of frame; ack_o pulses the cycle after spi_cs returns high. dat_o holds until the next read completes.
- Program/erase completion: ack_o pulses the cycle after spi_cs returns high. With the optional feature enabled, the POLL state runs first.
- DONE:
  - Entered on ack/rty; lasts 1 cycle; stb_i is ignored.
  - Then IDLE, with the gap counter reloaded to CS_GAP.
- Request changes: if stb_i drops mid-operation, the transaction still completes and ack_o still pulses. Changes on adr/dat/we/tga after acceptance are ignored.
- Pulse rules: ack_o and rty_o are never high together; each is high for exactly 1 cycle per accepted request.
- Nominal read latency (CLK_DIV=2): accept → ack = 1 + 64*4 + 1 = 258 clk cycles.

Optional Feature:
- Macro: FLASH_BUSY_POLL_EN.
- Defined:
  - After a program or erase frame, wait CS_GAP, then run repeated 0x05 frames (8 out + 8 in), each separated by CS_GAP.
  - Status bit0 (WIP)=0: ack_o.
  - POLL_MAX polls with WIP still 1: rty_o instead of ack_o.
- Undefined:
  - POLL state is absent; program/erase ack immediately after spi_cs rises.
  - The requester provides post-write waiting.
  - POLL_MAX is unused.

Test Plan:
- Read: adr=0x1FFD80, we=0, tga=0; flash model returns 0xB0 0x2E 0x7F 0x1E → SPI bytes 03 1F FD 80; dat_o=0xB02E7F1E; ack_o one pulse 258 cycles after accept (CLK_DIV=2).
- Erase: adr=0x1FFD80, we=1, tga=1 → frame 06, cs high ≥4 cycles, then frame 20 1F FD 80 (32 clocks); ack_o pulse; dat_o unchanged.
- Program: adr=0x1FFD84, dat=0xC0424300, we=1, tga=0 → frames 06 then 02 1F FD 84 C0 42 43 00; ack_o pulse.
- Illegal and reset cases:
  - we=0, tga=1 → rty_o pulse 1 cycle after accept; spi_cs never low.
  - rst pulsed mid-read after 20 SPI clocks → spi_cs=1, spi_clk=0 same cycle, no ack; a following read succeeds.
- Back-to-back: stb_i held high through ack → second request not accepted until DONE+CS_GAP; spi_cs-high gap ≥4 cycles measured.
- FLASH_BUSY_POLL_EN:
  - Model reports WIP=1 for 3 polls, then 0 → three extra 05 frames, then ack.
  - POLL_MAX=4, WIP stuck at 1 → exactly 4 polls, then rty_o.

Source files
------------

// File: rtl/spi_flash_target_if.sv
// Request/response bus between the MIDI controller storage logic and the flash target.
interface spi_flash_target_if;
  logic [23:0] adr_i;
  logic [31:0] dat_i;
  logic        we_i;
  logic        stb_i;
  logic        tga_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        rty_o;

  modport master (output adr_i, dat_i, we_i, stb_i, tga_i, input dat_o, ack_o, rty_o);
  modport slave  (input adr_i, dat_i, we_i, stb_i, tga_i, output dat_o, ack_o, rty_o);
endinterface

// File: rtl/spi_flash_target.sv
// Bus-to-SPI NOR bridge: read (03), program (06+02), sector erase (06+20), SPI mode 0.
// Define FLASH_BUSY_POLL_EN to poll the status register (05) for WIP after program/erase.
module spi_flash_target #(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_flash_target_if.slave    bus,
  output logic                 spi_clk,
  output logic                 spi_cs,
  output logic                 spi_di,
  input  logic                 spi_do
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

  typedef enum logic [2:0] {IDLE, WREN, GAP, XFER, POLL, DONE} state_t;

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic [DW-1:0]   div_cnt;
  logic [6:0]      bits_left;
  logic [63:0]     sh;
  logic [31:0]     rx;
  logic            active;
  logic [23:0]     adr_q;
  logic [31:0]     dat_q, dat_r;
  logic            we_q, tga_q, ack_q, rty_q;
  logic            last_edge;
`ifdef FLASH_BUSY_POLL_EN
  logic [31:0]     poll_cnt;
  logic            nxt_poll;
`else
  logic            unused_poll_max;
  assign unused_poll_max = (POLL_MAX != 0);
`endif

  assign bus.dat_o = dat_r;
  assign bus.ack_o = ack_q;
  assign bus.rty_o = rty_q;

  // Falling edge that closes the final bit of the current frame.
  assign last_edge = active && spi_clk && (div_cnt == DW'(CLK_DIV - 1)) && (bits_left == 7'd1);

  task automatic start_frame(input logic [63:0] f, input logic [6:0] n);
    sh        <= f;
    spi_di    <= f[63];
    bits_left <= n;
    div_cnt   <= '0;
    spi_cs    <= 1'b0;
    active    <= 1'b1;
  endtask

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= GW'(CS_GAP);
      div_cnt   <= '0;
      bits_left <= '0;
      sh        <= '0;
      rx        <= '0;
      active    <= 1'b0;
      spi_cs    <= 1'b1;
      spi_clk   <= 1'b0;
      spi_di    <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      tga_q     <= 1'b0;
      dat_r     <= '0;
      ack_q     <= 1'b0;
      rty_q     <= 1'b0;
`ifdef FLASH_BUSY_POLL_EN
      poll_cnt  <= '0;
      nxt_poll  <= 1'b0;
`endif
    end else begin
      // Bit engine: low half-period ends with a rising edge + sample, high half ends with the next bit.
      if (active) begin
        if (div_cnt != DW'(CLK_DIV - 1)) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          if (!spi_clk) begin
            spi_clk <= 1'b1;
            rx      <= {rx[30:0], spi_do};
          end else begin
            spi_clk   <= 1'b0;
            bits_left <= bits_left - 1'b1;
            if (bits_left == 7'd1) begin
              active <= 1'b0;
              spi_cs <= 1'b1;
              spi_di <= 1'b0;
            end else begin
              sh     <= {sh[62:0], 1'b0};
              spi_di <= sh[62];
            end
          end
        end
      end

      case (state)
        IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (bus.stb_i) begin
            adr_q <= bus.adr_i;
            dat_q <= bus.dat_i;
            we_q  <= bus.we_i;
            tga_q <= bus.tga_i;
            if (bus.tga_i && !bus.we_i) begin
              rty_q <= 1'b1;
              state <= DONE;
            end else if (bus.we_i) begin
              start_frame({8'h06, 56'h0}, 7'd8);
              state <= WREN;
            end else begin
              start_frame({8'h03, bus.adr_i, 32'h0}, 7'd64);
              state <= XFER;
            end
          end
        end
        WREN: if (last_edge) begin
          gap_cnt <= GW'(CS_GAP - 1);
          state   <= GAP;
`ifdef FLASH_BUSY_POLL_EN
          nxt_poll <= 1'b0;
`endif
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
`ifdef FLASH_BUSY_POLL_EN
          end else if (nxt_poll) begin
            start_frame({8'h05, 56'h0}, 7'd16);
            state <= POLL;
`endif
          end else begin
            if (tga_q) start_frame({8'h20, adr_q, 32'h0}, 7'd32);
            else       start_frame({8'h02, adr_q, dat_q}, 7'd64);
            state <= XFER;
          end
        end
        XFER: if (!active) begin
          if (!we_q) begin
            dat_r <= rx;
            ack_q <= 1'b1;
            state <= DONE;
          end else begin
`ifdef FLASH_BUSY_POLL_EN
            poll_cnt <= '0;
            nxt_poll <= 1'b1;
            gap_cnt  <= GW'(CS_GAP - 1);
            state    <= GAP;
`else
            ack_q <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef FLASH_BUSY_POLL_EN
        // rx[0] is the last bit shifted in: status bit0 (WIP).
        POLL: if (!active) begin
          if (!rx[0]) begin
            ack_q <= 1'b1;
            state <= DONE;
          end else if (poll_cnt + 32'd1 >= 32'(POLL_MAX)) begin
            rty_q <= 1'b1;
            state <= DONE;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
            gap_cnt  <= GW'(CS_GAP - 1);
            state    <= GAP;
          end
        end
`endif
        DONE: begin
          ack_q   <= 1'b0;
          rty_q   <= 1'b0;
          gap_cnt <= GW'(CS_GAP);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target with a cycle-sampled SPI NOR flash model.
module tb_spi_flash_target;
`ifdef FLASH_BUSY_POLL_EN
  localparam int PM = 4;
`else
  localparam int PM = 65535;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk, spi_cs, spi_di;
  logic spi_do = 1'b0;

  spi_flash_target_if bus ();

  spi_flash_target #(.CLK_DIV(2), .CS_GAP(4), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_di(spi_di), .spi_do(spi_do)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Flash model state (written only by the model process).
  int          bi = 0, nclk = 0, hi_run = 0, last_gap = 0, fr_n = 0, poll_frames = 0;
  logic [63:0] mosi = '0;
  logic [7:0]  cmd = '0;
  logic        p_cs = 1'b1, p_sc = 1'b0;
  int          fr_len [256];
  logic [63:0] fr_dat [256];
  // Stimulus-owned model controls.
  logic [31:0] rd_data = '0;
  int          poll_base = 0, wip_polls = 0;
  // Bus monitor.
  int          ack_cnt = 0, rty_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    logic [7:0] stat;
    logic       b;
    if (p_cs && !spi_cs) begin
      bi = 0; nclk = 0; mosi = '0; cmd = '0; last_gap = hi_run;
    end
    if (spi_cs) hi_run++; else hi_run = 0;
    if (!spi_cs && !p_sc && spi_clk) begin
      mosi = {mosi[62:0], spi_di};
      nclk++;
      if (nclk == 8) cmd = mosi[7:0];
    end
    if (!spi_cs && p_sc && !spi_clk) bi++;
    if (!p_cs && spi_cs) begin
      fr_len[fr_n] = nclk;
      fr_dat[fr_n] = mosi;
      fr_n++;
      if (cmd == 8'h05) poll_frames++;
    end
    stat = {7'b0, ((poll_frames - poll_base) < wip_polls)};
    b = 1'b0;
    if (cmd == 8'h05 && bi >= 8 && bi < 16)       b = stat[15 - bi];
    else if (cmd == 8'h03 && bi >= 32 && bi < 64) b = rd_data[63 - bi];
    spi_do <= b;
    p_cs = spi_cs;
    p_sc = spi_clk;
  end

  always @(posedge clk) begin
    if (bus.ack_o) ack_cnt++;
    if (bus.rty_o) rty_cnt++;
    if (bus.ack_o && bus.rty_o) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request; n = clk edges from the accept edge to the first response cycle.
  task automatic do_req(input logic [23:0] a, input logic [31:0] d, input logic w, input logic t,
                        input logic hold, output int n, output logic ga, output logic gr);
    @(negedge clk);
    bus.adr_i = a; bus.dat_i = d; bus.we_i = w; bus.tga_i = t; bus.stb_i = 1'b1;
    n = 0; ga = 1'b0; gr = 1'b0;
    while (!ga && !gr && n < 5000) begin
      @(posedge clk); #1;
      n++;
      ga = bus.ack_o;
      gr = bus.rty_o;
    end
    if (!hold) bus.stb_i = 1'b0;
  endtask

  task automatic chk_pulse_end(input string tag);
    @(posedge clk); #1;
    chk(tag, {62'b0, bus.ack_o, bus.rty_o}, 64'd0);
  endtask

  initial begin
    int   n, m, base, acks0, k;
    logic ga, gr;
    bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.tga_i = 1'b0; bus.stb_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", spi_cs, 1);
    chk("reset_sclk", spi_clk, 0);
    chk("reset_di", spi_di, 0);
    chk("reset_dat", bus.dat_o, 0);
    chk("reset_ack_rty", {bus.ack_o, bus.rty_o}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);

    // Read
    rd_data = 32'hB02E7F1E;
    base = fr_n;
    do_req(24'h1FFD80, 32'h0, 1'b0, 1'b0, 1'b0, n, ga, gr);
    chk("rd_ack", {ga, gr}, 2'b10);
    chk("rd_latency", n, 258);
    chk("rd_dat", bus.dat_o, 32'hB02E7F1E);
    chk_pulse_end("rd_pulse");
    chk("rd_frames", fr_n - base, 1);
    chk("rd_len", fr_len[base], 64);
    chk("rd_mosi", fr_dat[base], 64'h031FFD80_00000000);
    repeat (10) @(posedge clk);

    // Erase
    base = fr_n;
    do_req(24'h1FFD80, 32'h0, 1'b1, 1'b1, 1'b0, n, ga, gr);
    chk("er_ack", {ga, gr}, 2'b10);
    chk("er_dat_hold", bus.dat_o, 32'hB02E7F1E);
    chk_pulse_end("er_pulse");
    chk("er_wren", {fr_len[base][7:0], fr_dat[base][7:0]}, 16'h0806);
    chk("er_len", fr_len[base+1], 32);
    chk("er_mosi", fr_dat[base+1][31:0], 32'h201FFD80);
`ifndef FLASH_BUSY_POLL_EN
    chk("er_latency", n, 166);
    chk("er_frames", fr_n - base, 2);
    chk("er_gap", last_gap, 4);
`endif
    repeat (10) @(posedge clk);

    // Program
    base = fr_n;
    do_req(24'h1FFD84, 32'hC0424300, 1'b1, 1'b0, 1'b0, n, ga, gr);
    chk("pg_ack", {ga, gr}, 2'b10);
    chk_pulse_end("pg_pulse");
    chk("pg_wren", {fr_len[base][7:0], fr_dat[base][7:0]}, 16'h0806);
    chk("pg_len", fr_len[base+1], 64);
    chk("pg_mosi", fr_dat[base+1], 64'h021FFD84_C0424300);
`ifndef FLASH_BUSY_POLL_EN
    chk("pg_latency", n, 294);
    chk("pg_frames", fr_n - base, 2);
    chk("pg_gap", last_gap, 4);
`endif
    repeat (10) @(posedge clk);

    // Illegal combination: read with tga set
    base = fr_n;
    do_req(24'h000040, 32'h0, 1'b0, 1'b1, 1'b0, n, ga, gr);
    chk("ill_rty", {ga, gr}, 2'b01);
    chk("ill_latency", n, 1);
    chk_pulse_end("ill_pulse");
    repeat (5) @(posedge clk);
    chk("ill_no_frames", fr_n - base, 0);
    repeat (5) @(posedge clk);

    // Reset after 20 SPI clocks of a read
    rd_data = 32'h5AA501FE;
    @(negedge clk);
    bus.adr_i = 24'h000123; bus.we_i = 1'b0; bus.tga_i = 1'b0; bus.stb_i = 1'b1;
    k = 0;
    while (nclk < 20 && k < 1000) begin @(posedge clk); k++; end
    chk("rst_reach20", (nclk >= 20), 1);
    acks0 = ack_cnt;
    #3 rst = 1'b1;
    #1;
    chk("rst_cs_async", spi_cs, 1);
    chk("rst_sclk_async", spi_clk, 0);
    chk("rst_dat", bus.dat_o, 0);
    bus.stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_ack", ack_cnt - acks0, 0);
    do_req(24'h000123, 32'h0, 1'b0, 1'b0, 1'b0, n, ga, gr);
    chk("rst_rd_ack", {ga, gr}, 2'b10);
    chk("rst_rd_latency", n, 258);
    chk("rst_rd_dat", bus.dat_o, 32'h5AA501FE);
    repeat (10) @(posedge clk);

    // Back-to-back reads with stb held through ack
    rd_data = 32'h12345678;
    acks0 = ack_cnt;
    do_req(24'h000010, 32'h0, 1'b0, 1'b0, 1'b1, n, ga, gr);
    chk("b2b_first", n, 258);
    m = 0; ga = 1'b0;
    while (!ga && m < 1000) begin @(posedge clk); #1; m++; ga = bus.ack_o; end
    bus.stb_i = 1'b0;
    chk("b2b_second", m, 263);
    chk("b2b_gap", (last_gap >= 4), 1);
    chk("b2b_dat", bus.dat_o, 32'h12345678);
    repeat (3) @(posedge clk);
    chk("b2b_acks", ack_cnt - acks0, 2);

`ifdef FLASH_BUSY_POLL_EN
    repeat (10) @(posedge clk);
    poll_base = poll_frames; wip_polls = 3;
    do_req(24'h000200, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, n, ga, gr);
    chk("poll_ack", {ga, gr}, 2'b10);
    chk("poll_count", poll_frames - poll_base, 4);
    repeat (10) @(posedge clk);
    poll_base = poll_frames; wip_polls = 1000;
    do_req(24'h001000, 32'h0, 1'b1, 1'b1, 1'b0, n, ga, gr);
    chk("poll_max_rty", {ga, gr}, 2'b01);
    chk("poll_max_count", poll_frames - poll_base, 4);
    wip_polls = 0;
`endif

    chk("ack_rty_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
